// File: rtl/hash_arbiter.sv
// Round-robin arbiter sharing one padder + Keccak core between NREQ message requesters.
// Optional idle-feed watchdog with abort pulse: define HASH_ARB_WATCHDOG_EN.
module hash_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned IDW     = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ*64-1:0]  req_in,
    input  logic [NREQ-1:0]     req_in_ready,
    input  logic [NREQ-1:0]     req_is_last,
    input  logic [NREQ*3-1:0]   req_byte_num,
    output logic [NREQ-1:0]     req_accept,
    output logic [NREQ-1:0]     res_valid,
    input  logic [NREQ-1:0]     res_ack,
    output logic [63:0]         pad_in,
    output logic                pad_in_ready,
    output logic                pad_is_last,
    output logic [2:0]          pad_byte_num,
    input  logic                pad_buffer_full,
    output logic                core_reset,
    input  logic                core_out_ready,
    output logic [IDW-1:0]      grant_id,
`ifdef HASH_ARB_WATCHDOG_EN
    output logic                abort,
`endif
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        WAIT,
        DELIVER
    } state_t;

    state_t state, next_state;

    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    hit_id;
    logic [IDW-1:0]    next_ptr;
    logic              hit;
    logic              own_ready;
    logic              own_ack;
    logic              timeout;
    logic [2*NREQ-1:0] ready_dbl;
    logic [NREQ-1:0]   ready_rot;
    logic [NREQ-1:0]   owner_onehot;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                                input int unsigned   off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NREQ) sum = sum - NREQ;
        return IDW'(sum);
    endfunction

    // Rotating the doubled request vector puts rr_ptr at bit 0, so the
    // lowest set bit of ready_rot is the round-robin winner.
    assign ready_dbl = {req_in_ready, req_in_ready} >> rr_ptr;
    assign ready_rot = ready_dbl[NREQ-1:0];

    always_comb begin
        hit    = 1'b0;
        hit_id = '0;
        for (int unsigned i = NREQ; i > 0; i--) begin
            if (ready_rot[i-1]) begin
                hit    = 1'b1;
                hit_id = wrap_add(rr_ptr, i - 1);
            end
        end
    end

    always_comb begin
        pad_in       = '0;
        pad_is_last  = 1'b0;
        pad_byte_num = '0;
        own_ready    = 1'b0;
        own_ack      = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (32'(grant_id) == k) begin
                pad_in       = req_in[64*k +: 64];
                pad_is_last  = req_is_last[k];
                pad_byte_num = req_byte_num[3*k +: 3];
                own_ready    = req_in_ready[k];
                own_ack      = res_ack[k];
            end
        end
    end

    assign next_ptr     = (32'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
    assign owner_onehot = {{(NREQ-1){1'b0}}, 1'b1} << grant_id;

`ifdef HASH_ARB_WATCHDOG_EN
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] wd_cnt;

    assign timeout = (state == FEED) && (32'(wd_cnt) == TIMEOUT);
    assign abort   = timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if (state != FEED || pad_in_ready) begin
            wd_cnt <= '0;
        end else if (!timeout) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        next_state   = state;
        pad_in_ready = 1'b0;
        case (state)
            IDLE: begin
                if (hit) next_state = FEED;
            end
            FEED: begin
                if (timeout) begin
                    next_state = IDLE;
                end else begin
                    pad_in_ready = own_ready & ~pad_buffer_full;
                    if (pad_in_ready && pad_is_last) next_state = WAIT;
                end
            end
            WAIT: begin
                if (!core_reset && core_out_ready) next_state = DELIVER;
            end
            DELIVER: begin
                if (own_ack) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        req_accept = pad_in_ready ? owner_onehot : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            res_valid  <= '0;
            core_reset <= 1'b1;
        end else begin
            state      <= next_state;
            // Clear is held throughout IDLE so each message starts from a fresh core.
            core_reset <= (next_state == IDLE);
            if (state == IDLE && hit) grant_id <= hit_id;
            if (state == WAIT && next_state == DELIVER) res_valid <= owner_onehot;
            if (state == DELIVER && own_ack) begin
                res_valid <= '0;
                rr_ptr    <= next_ptr;
            end
            if (timeout) rr_ptr <= next_ptr;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_hash_arbiter.sv
// Randomized scoreboard bench for hash_arbiter: per-requester word queues plus a
// transaction-level ownership model checked at every falling clock edge.
module tb_hash_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned IDW  = 2;

    localparam int NO_OWNER     = 0;
    localparam int STREAMING    = 1;
    localparam int AWAIT_DIGEST = 2;
    localparam int DIGEST_HELD  = 3;

    typedef logic [67:0] word_t;  // {is_last, byte_num, data}

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ*64-1:0]  req_in;
    logic [NREQ-1:0]     req_in_ready;
    logic [NREQ-1:0]     req_is_last;
    logic [NREQ*3-1:0]   req_byte_num;
    logic [NREQ-1:0]     req_accept;
    logic [NREQ-1:0]     res_valid;
    logic [NREQ-1:0]     res_ack;
    logic [63:0]         pad_in;
    logic                pad_in_ready;
    logic                pad_is_last;
    logic [2:0]          pad_byte_num;
    logic                pad_buffer_full;
    logic                core_reset;
    logic                core_out_ready;
    logic [IDW-1:0]      grant_id;
    logic                busy;
`ifdef HASH_ARB_WATCHDOG_EN
    logic                abort;
`endif

    always #5 clk = ~clk;

    hash_arbiter #(
        .NREQ   (NREQ),
        .IDW    (IDW),
        .TIMEOUT(255)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_in         (req_in),
        .req_in_ready   (req_in_ready),
        .req_is_last    (req_is_last),
        .req_byte_num   (req_byte_num),
        .req_accept     (req_accept),
        .res_valid      (res_valid),
        .res_ack        (res_ack),
        .pad_in         (pad_in),
        .pad_in_ready   (pad_in_ready),
        .pad_is_last    (pad_is_last),
        .pad_byte_num   (pad_byte_num),
        .pad_buffer_full(pad_buffer_full),
        .core_reset     (core_reset),
        .core_out_ready (core_out_ready),
        .grant_id       (grant_id),
`ifdef HASH_ARB_WATCHDOG_EN
        .abort          (abort),
`endif
        .busy           (busy)
    );

    word_t drv_q [NREQ][$];
    word_t exp_q [NREQ][$];

    int              tests = 0;
    int              fails = 0;
    int              m_phase;
    int unsigned     m_owner;
    int unsigned     m_next;
    logic [NREQ-1:0] m_res;
    logic [NREQ-1:0] acc_seen;
    bit              gen_en;

    // monitor scratch
    bit              exp_busy;
    bit              exp_pir;
    bit              found;
    int unsigned     cand;
    logic [NREQ-1:0] exp_acc;
    word_t           w_exp;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = NO_OWNER;
        m_owner = 0;
        m_next  = 0;
        m_res   = '0;
    endtask

    task automatic check_reset_values();
        check("rst_busy", busy, 1'b0);
        check("rst_core_reset", core_reset, 1'b1);
        check("rst_res_valid", res_valid, '0);
        check("rst_grant_id", grant_id, '0);
        check("rst_req_accept", req_accept, '0);
        check("rst_pad_in_ready", pad_in_ready, 1'b0);
    endtask

    task automatic push_word(input int unsigned k, input word_t w);
        drv_q[k].push_back(w);
        exp_q[k].push_back(w);
    endtask

    task automatic new_message(input int unsigned k);
        int unsigned len;
        logic        last;
        len = $urandom_range(1, 6);
        for (int unsigned i = 0; i < len; i++) begin
            last = (i == len - 1);
            push_word(k, {last, 3'($urandom_range(0, 7)), $urandom, $urandom});
        end
    endtask

    task automatic drive_cycle();
        word_t w;
        @(posedge clk);
        #1;
        for (int unsigned k = 0; k < NREQ; k++)
            if (acc_seen[k] && drv_q[k].size() > 0) void'(drv_q[k].pop_front());
        acc_seen = '0;
        for (int unsigned k = 0; k < NREQ; k++)
            if (gen_en && drv_q[k].size() == 0 && $urandom_range(0, 7) == 0) new_message(k);
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (drv_q[k].size() > 0) begin
                w = drv_q[k][0];
                req_in_ready[k] = ($urandom_range(0, 4) != 0);
            end else begin
                w = {4'($urandom_range(0, 15)), $urandom, $urandom};
                req_in_ready[k] = 1'b0;
            end
            req_in[64*k +: 64]      = w[63:0];
            req_byte_num[3*k +: 3]  = w[66:64];
            req_is_last[k]          = w[67];
            res_ack[k]              = ($urandom_range(0, 3) == 0);
        end
        pad_buffer_full = ($urandom_range(0, 3) == 0);
        core_out_ready  = ($urandom_range(0, 2) == 0);
    endtask

    // Monitor: compare the DUT against the ownership model, then advance the model.
    always @(negedge clk) begin
        if (reset) begin
            acc_seen = req_accept;
            exp_busy = (m_phase != NO_OWNER);
            check("busy", busy, exp_busy);
            check("core_reset", core_reset, !exp_busy);
            check("res_valid", res_valid, m_res);
            if (exp_busy) check("grant_id", grant_id, m_owner[IDW-1:0]);
            exp_acc = '0;
            exp_pir = 1'b0;
            case (m_phase)
                NO_OWNER: begin
                    found = 1'b0;
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        cand = (m_next + i) % NREQ;
                        if (!found && req_in_ready[cand]) begin
                            found   = 1'b1;
                            m_owner = cand;
                        end
                    end
                    if (found) m_phase = STREAMING;
                end
                STREAMING: begin
                    exp_pir = req_in_ready[m_owner] && !pad_buffer_full;
                    if (exp_pir) begin
                        exp_acc[m_owner] = 1'b1;
                        if (exp_q[m_owner].size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL pad_word: accept from requester %0d with no word expected", m_owner);
                        end else begin
                            w_exp = exp_q[m_owner].pop_front();
                            check("pad_word", {pad_is_last, pad_byte_num, pad_in}, w_exp);
                            if (w_exp[67]) m_phase = AWAIT_DIGEST;
                        end
                    end
                end
                AWAIT_DIGEST: begin
                    if (core_out_ready) begin
                        m_res          = '0;
                        m_res[m_owner] = 1'b1;
                        m_phase        = DIGEST_HELD;
                    end
                end
                default: begin
                    if (res_ack[m_owner]) begin
                        m_res   = '0;
                        m_next  = (m_owner + 1) % NREQ;
                        m_phase = NO_OWNER;
                    end
                end
            endcase
            check("pad_in_ready", pad_in_ready, exp_pir);
            check("req_accept", req_accept, exp_acc);
        end
    end

    initial begin
        int  budget;
        bit  drained;
        reset           = 1'b0;
        req_in          = '0;
        req_in_ready    = '0;
        req_is_last     = '0;
        req_byte_num    = '0;
        res_ack         = '0;
        pad_buffer_full = 1'b0;
        core_out_ready  = 1'b0;
        acc_seen        = '0;
        gen_en          = 1'b0;
        model_reset();

        #12;
        check_reset_values();
        @(posedge clk);
        #1 reset = 1'b1;

        // Directed opening: long message on 0, single-word empty message on 1,
        // short message on 2, all contending from reset.
        for (int i = 0; i < 8; i++) push_word(0, {1'b0, 3'd0, 64'h1234567890ABCDEF});
        push_word(0, {1'b1, 3'd6, 64'h1234567890ABCDEF});
        push_word(1, {1'b1, 3'd0, 64'hDEADBEEF00C0FFEE});
        push_word(2, {1'b0, 3'd3, 64'h0123456789ABCDEF});
        push_word(2, {1'b1, 3'd5, 64'hFEDCBA9876543210});

        repeat (80) drive_cycle();
        gen_en = 1'b1;
        repeat (2000) drive_cycle();

        // Reset in the middle of a message stream.
        budget = 0;
        while (m_phase != STREAMING && budget < 500) begin
            drive_cycle();
            budget++;
        end
        if (m_phase != STREAMING) begin
            tests++;
            fails++;
            $display("FAIL mid_reset_wait: no message in flight within %0d cycles", budget);
        end
        repeat (2) drive_cycle();
        reset        = 1'b0;
        req_in_ready = '0;
        #1;
        check_reset_values();
        for (int unsigned k = 0; k < NREQ; k++) begin
            drv_q[k].delete();
            exp_q[k].delete();
        end
        model_reset();
        acc_seen = '0;
        @(posedge clk);
        #1 reset = 1'b1;
        acc_seen = '0;

        repeat (2000) drive_cycle();

        gen_en  = 1'b0;
        drained = 1'b0;
        for (int i = 0; i < 3000 && !drained; i++) begin
            drive_cycle();
            drained = (m_phase == NO_OWNER);
            for (int unsigned k = 0; k < NREQ; k++)
                if (drv_q[k].size() != 0) drained = 1'b0;
        end
        check("drain_done", drained, 1'b1);
        for (int unsigned k = 0; k < NREQ; k++)
            check("words_left", exp_q[k].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hash_arbiter.md
Name: hash_arbiter

Overview:
- Shares one padder + Keccak permutation core between NREQ message requesters.
- Grants the core for a whole message using round-robin order.
- Muxes the owner's 64-bit word stream into the padder and holds the core in reset between messages.
- Signals hash completion to the owning requester, which reads the digest from the core output directly.

Parameters:
NREQ, 2, number of requesters (2..8)
IDW, 1, width of grant_id; must satisfy 2**IDW >= NREQ
TIMEOUT, 255, idle-feed cycle limit (used only with HASH_ARB_WATCHDOG_EN)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
req_in  in  NREQ*64  data words; requester k on bits [64k+63:64k]
req_in_ready  in  NREQ  requester k has a valid word
req_is_last  in  NREQ  word is the final word of the message
req_byte_num  in  NREQ*3  valid bytes in the last word; requester k on [3k+2:3k]
req_accept  out  NREQ  word of requester k consumed this cycle (combinational)
res_valid  out  NREQ  digest ready for requester k (registered, one-hot)
res_ack  in  NREQ  requester k has taken its digest
pad_in  out  64  word to padder
pad_in_ready  out  1  word valid to padder
pad_is_last  out  1  last-word flag to padder
pad_byte_num  out  3  byte count to padder
pad_buffer_full  in  1  padder cannot take a word
core_reset  out  1  synchronous active-high clear to padder/core (registered)
core_out_ready  in  1  core digest valid (level)
grant_id  out  IDW  current owner index
busy  out  1  state != IDLE

Behaviour:
- Reset values: state IDLE, rr_ptr 0, grant_id 0, res_valid 0, core_reset 1, busy 0.
- Reset mid-message discards the message; no accept is reported for the cycle reset is asserted.
- IDLE state:
  - core_reset = 1.
  - Search req_in_ready starting at rr_ptr, wrapping modulo NREQ.
  - First hit k: grant_id <= k, go to FEED next cycle.
  - Grant latency is 1 cycle; core_reset is held for at least 1 full cycle before any word is forwarded.
- FEED state:
  - core_reset = 0.
  - pad_in, pad_is_last and pad_byte_num are muxed combinationally from owner grant_id.
  - pad_in_ready = req_in_ready[owner] & ~pad_buffer_full.
  - req_accept[owner] = pad_in_ready; every other req_accept bit is 0.
  - A word with is_last=1 that is accepted moves the state to WAIT.
  - Non-owner requests are ignored until the next IDLE.
- WAIT state:
  - pad_in_ready = 0.
  - On core_reset-free cycle with core_out_ready = 1: res_valid[owner] <= 1, go to DELIVER.
- DELIVER state:
  - Hold res_valid[owner] and keep core_reset = 0 so the digest stays stable.
  - On res_ack[owner] = 1: res_valid <= 0, rr_ptr <= (owner+1) mod NREQ, go to IDLE.
  - res_ack from non-owners is ignored.
- Simultaneous requests in IDLE: the lowest index at or after rr_ptr wins.
- The same requester cannot win twice in a row while another requester is pending.
- An accept of is_last in FEED with pad_buffer_full=1 cannot occur (gated); the word waits.
- byte_num passes through unaltered; it is meaningful only with is_last.

Optional Feature:
- HASH_ARB_WATCHDOG_EN defined:
  - A counter clears on every accepted word and increments each FEED cycle with no accept.
  - At count == TIMEOUT the arbiter aborts: go to IDLE (core_reset reasserts), rr_ptr <= owner+1, and pulse output abort (1 bit, 1 cycle) with grant_id still showing the owner.
  - The abort port exists only when the macro is defined.
- HASH_ARB_WATCHDOG_EN undefined: no counter and no abort port; FEED waits indefinitely.

Test Plan:
1. Single message: after reset, req0 sends 8 words 64'h1234567890ABCDEF with is_last on word 9 (byte_num 6), core_out_ready pulses → grant_id=0, core_reset drops 1 cycle after request, 9 req_accept[0] pulses, res_valid=2'b01 until res_ack[0], then busy=0 and core_reset=1.
2. Contention: req0 and req1 both request in the same IDLE cycle from reset → req0 served first; req1 is served next even though req0 re-requests immediately; grant order 0,1,0.
3. Backpressure: pad_buffer_full=1 for 3 cycles in mid-FEED with req_in_ready=1 → pad_in_ready=0 and req_accept=0 for those cycles; no word is lost or duplicated (count accepts = 9).
4. Empty message: req1 sends a single word with is_last=1, byte_num=0 → exactly one accept, WAIT state, res_valid=2'b10 after core_out_ready.
5. Reset mid-FEED after 4 words → all outputs return to reset values immediately; the next grant starts from requester 0.
6. With HASH_ARB_WATCHDOG_EN and TIMEOUT=10: owner stalls after 2 words → abort pulses exactly 11 cycles after the last accept, core_reset=1, the other requester is granted next.
